mux_store_sync: RTL and testbench
=================================

# mux_store_sync

Parametrised multiplexer-with-storage for the video datapath, generalising the quad 2-input mux/register to N inputs, arbitrary width and a programmable history depth. It operates in the single system clock domain. The stored word updates only on a detected active edge of the clock-enable strobe `Cen`, which is qualified by a `HOLD` input. Each capture pushes the previous stored word into a shift history with per-stage valid flags and raises a one-cycle strobe. It replaces chained discrete mux-latch stages in the video pipeline.

## Interface
- `WIDTH`, default 4: bits per data word, ≥1.
- `NIN`, default 2: number of mux inputs, ≥2.
- `SELW`, default `$clog2(NIN)`: select width.
- `DEPTH`, default 1: history stages behind `Q`, ≥1.
- `EDGE`, default 0: active `Cen` edge; 0 = falling, 1 = rising.
- `clk`, input, 1: system clock; all state changes on its rising edge.
- `VIDEO_RST`, input, 1: asynchronous reset, active-high.
- `Cen`, input, 1: capture strobe, synchronous to `clk`; only its active edge matters.
- `HOLD`, input, 1: when 1, a detected edge is ignored.
- `SEL`, input, `SELW`: input select.
- `D`, input, `NIN*WIDTH`: flattened inputs; input k is `D[k*WIDTH +: WIDTH]`.
- `Q`, output, `WIDTH`: current stored word.
- `H`, output, `DEPTH*WIDTH`: history; stage j is `H[j*WIDTH +: WIDTH]`, stage 0 is the newest.
- `HV`, output, `DEPTH`: valid flag per history stage.
- `QV`, output, 1: `Q` holds a captured word.
- `STB`, output, 1: pulses for one cycle after each capture.

## Operation
- Edge detector: register `last_cen` samples `Cen` every cycle. An edge is detected when the following holds at the rising edge of `clk`:
  - EDGE=0: `Cen`=0 and `last_cen`=1.
  - EDGE=1: `Cen`=1 and `last_cen`=0.
- Capture = edge detected AND `HOLD`=0. On a capture:
  - `Q` ← `D[SEL]`.
  - `H[0]` ← old `Q`; `H[j]` ← old `H[j-1]`; the oldest stage is discarded.
  - `HV[0]` ← old `QV`; `HV[j]` ← old `HV[j-1]`.
  - `QV` ← 1.
  - `STB` ← 1 for the next cycle.
- Without a capture, all storage is held and `STB` ← 0.
- `SEL` ≥ `NIN` (non-power-of-2 `NIN`) selects input 0.
- `Cen` held at its active level produces exactly one capture; the next capture requires a return to the idle level.
- An edge that occurs while `HOLD`=1 is consumed: `last_cen` still updates, so deasserting `HOLD` while `Cen` stays at its active level does not capture.
- No X states. Every input combination has defined behaviour.

## Timing
- Reset, asynchronous, applied immediately:
  - `Q`, `H` = 0.
  - `QV`, `HV`, `STB` = 0.
  - `last_cen` = 1 when EDGE=0, 0 when EDGE=1 (idle level).
- After reset release, if `Cen` is already at its active level at the first rising edge of `clk`, that edge is a capture.
- Capture latency:
  - `D`, `SEL` and `HOLD` are sampled at the same rising edge of `clk` at which `Cen` is first sampled at its active level.
  - `Q`, `H`, `HV` and `QV` are visible after that edge.
  - `STB` is high for exactly the following cycle.
- Minimum capture spacing: 2 `clk` cycles (active, idle, active). Back-to-back `STB` pulses are then 2 cycles apart.
- `HV` fills one stage per capture. `HV` is all-ones after `DEPTH`+1 captures.
- Reset asserted mid-stream clears everything in the same cycle. A `Cen` edge coincident with the reset deassertion edge is ignored; detection starts at the next rising edge of `clk`.

## Test plan
- Reset and basic capture (WIDTH=4, NIN=2, DEPTH=1, EDGE=0):
  - Stimulus: assert reset; `Cen`=1; `D`={B=4'hA, A=4'h5}; `SEL`=1; drop `Cen` for 1 cycle.
  - Required: `Q`=4'hA, `QV`=1, `STB` one pulse, `H`=0, `HV`=0.
  - Then `SEL`=0 and a second drop. Required: `Q`=5, `H[0]`=4'hA, `HV`=1.
- Level-held `Cen`:
  - Stimulus: hold `Cen`=0 for 10 cycles.
  - Required: exactly 1 capture and 1 `STB`.
  - Then toggle `Cen` 1/0 every cycle for 8 cycles. Required: 4 captures, `STB` every 2nd cycle.
- `HOLD`:
  - Stimulus: falling edge of `Cen` with `HOLD`=1; drop `HOLD` while `Cen` stays low.
  - Required: `Q`, `H` and `QV` unchanged; no `STB`.
  - Then the next falling edge with `HOLD`=0. Required: capture.
- History fill (NIN=3, WIDTH=8, DEPTH=3):
  - Stimulus: capture values 0x11, 0x22, 0x33, 0x44, 0x55 in order.
  - Required: `Q`=0x55; `H`={0x22, 0x33, 0x44} (stage 2 to 0); `HV`=3'b111.
  - Required: `SEL`=3 captures input 0.
- Rising-edge mode and reset mid-stream (EDGE=1):
  - Stimulus: `Cen` rise with `D[SEL]`=0x7.
  - Required: `Q`=7.
  - Then pulse reset between captures. Required: all outputs 0 immediately.
  - Then a `Cen`=1 edge at the first rising edge of `clk` after reset release (no coincident edge). Required: capture.

Source files
------------

// File: rtl/mux_store_sync.sv
// N-input multiplexer with an edge-qualified capture register and a shift history.
// The stored word only updates on a detected active edge of Cen while HOLD is low.
module mux_store_sync #(
    parameter int WIDTH = 4,
    parameter int NIN   = 2,
    parameter int SELW  = $clog2(NIN),
    parameter int DEPTH = 1,
    parameter int EDGE  = 0
) (
    input  logic                   clk,
    input  logic                   VIDEO_RST,
    input  logic                   Cen,
    input  logic                   HOLD,
    input  logic [SELW-1:0]        SEL,
    input  logic [NIN*WIDTH-1:0]   D,
    output logic [WIDTH-1:0]       Q,
    output logic [DEPTH*WIDTH-1:0] H,
    output logic [DEPTH-1:0]       HV,
    output logic                   QV,
    output logic                   STB
);

    // Cen level that arms the detector; an edge is a departure from it
    localparam logic CEN_IDLE = (EDGE == 0) ? 1'b1 : 1'b0;
    localparam int   NSLOT    = 2 ** SELW;

    logic                   last_cen_q, last_cen_d;
    logic [WIDTH-1:0]       q_q, q_d;
    logic [DEPTH*WIDTH-1:0] h_q, h_d;
    logic [DEPTH-1:0]       hv_q, hv_d;
    logic                   qv_q, qv_d;
    logic                   stb_q, stb_d;

    logic                   edge_s;
    logic                   capture_s;
    logic [WIDTH-1:0]       sel_word_s;
    logic [WIDTH-1:0]       d_arr [NSLOT];

    // Unused select codes fold back onto input 0
    for (genvar k = 0; k < NSLOT; k++) begin : g_in
        if (k < NIN) begin : g_real
            assign d_arr[k] = D[k*WIDTH +: WIDTH];
        end else begin : g_fold
            assign d_arr[k] = D[WIDTH-1:0];
        end
    end

    assign sel_word_s = d_arr[SEL];

    // Edge detection and capture qualification
    always_comb begin
        if (EDGE == 0) begin
            edge_s = ~Cen & last_cen_q;
        end else begin
            edge_s = Cen & ~last_cen_q;
        end
        capture_s = edge_s & ~HOLD;
    end

    // Next-state for the stored word, history and strobe
    always_comb begin
        last_cen_d = Cen;
        q_d        = q_q;
        h_d        = h_q;
        hv_d       = hv_q;
        qv_d       = qv_q;
        stb_d      = capture_s;
        if (capture_s) begin
            q_d               = sel_word_s;
            h_d[WIDTH-1:0]    = q_q;
            hv_d[0]           = qv_q;
            for (int j = 1; j < DEPTH; j++) begin
                h_d[j*WIDTH +: WIDTH] = h_q[(j-1)*WIDTH +: WIDTH];
                hv_d[j]               = hv_q[j-1];
            end
            qv_d              = 1'b1;
        end else begin
            q_d  = q_q;
            h_d  = h_q;
            hv_d = hv_q;
            qv_d = qv_q;
        end
    end

    // State registers; reset re-arms the detector at the idle level
    always_ff @(posedge clk or posedge VIDEO_RST) begin
        if (VIDEO_RST) begin
            last_cen_q <= CEN_IDLE;
            q_q        <= '0;
            h_q        <= '0;
            hv_q       <= '0;
            qv_q       <= 1'b0;
            stb_q      <= 1'b0;
        end else begin
            last_cen_q <= last_cen_d;
            q_q        <= q_d;
            h_q        <= h_d;
            hv_q       <= hv_d;
            qv_q       <= qv_d;
            stb_q      <= stb_d;
        end
    end

    assign Q   = q_q;
    assign H   = h_q;
    assign HV  = hv_q;
    assign QV  = qv_q;
    assign STB = stb_q;

endmodule

// File: tb/tb_mux_store_sync.sv
// Bench for mux_store_sync: three configurations checked every cycle against a
// capture-log reference model, plus a directed vector table and hand sequences.
module tb_mux_store_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // u0: WIDTH 4, NIN 2, DEPTH 1, falling edge
    logic c0, h0; logic [0:0] s0; logic [7:0] d0;
    logic [3:0] q0, hh0; logic [0:0] hv0; logic qv0, stb0;
    // u1: WIDTH 8, NIN 3, DEPTH 3, falling edge
    logic c1, h1; logic [1:0] s1; logic [23:0] d1;
    logic [7:0] q1; logic [23:0] hh1; logic [2:0] hv1; logic qv1, stb1;
    // u2: WIDTH 8, NIN 3, DEPTH 2, rising edge
    logic c2, h2; logic [1:0] s2; logic [23:0] d2;
    logic [7:0] q2; logic [15:0] hh2; logic [1:0] hv2; logic qv2, stb2;

    mux_store_sync #(.WIDTH(4), .NIN(2), .DEPTH(1), .EDGE(0)) u0 (
        .clk(clk), .VIDEO_RST(rst), .Cen(c0), .HOLD(h0), .SEL(s0), .D(d0),
        .Q(q0), .H(hh0), .HV(hv0), .QV(qv0), .STB(stb0));
    mux_store_sync #(.WIDTH(8), .NIN(3), .DEPTH(3), .EDGE(0)) u1 (
        .clk(clk), .VIDEO_RST(rst), .Cen(c1), .HOLD(h1), .SEL(s1), .D(d1),
        .Q(q1), .H(hh1), .HV(hv1), .QV(qv1), .STB(stb1));
    mux_store_sync #(.WIDTH(8), .NIN(3), .DEPTH(2), .EDGE(1)) u2 (
        .clk(clk), .VIDEO_RST(rst), .Cen(c2), .HOLD(h2), .SEL(s2), .D(d2),
        .Q(q2), .H(hh2), .HV(hv2), .QV(qv2), .STB(stb2));

    localparam int NIN_T [3] = '{2, 3, 3};
    localparam int W_T   [3] = '{4, 8, 8};
    localparam int DEP_T [3] = '{1, 3, 2};
    localparam int EDG_T [3] = '{0, 0, 1};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: a log of every captured word; outputs derive from its tail
    logic [7:0] log_w [3][4096];
    int         n_cap  [3];
    logic       prev_c [3];
    logic       stb_e  [3];

    function automatic logic get_cen(int i);
        case (i)
            0: return c0;
            1: return c1;
            default: return c2;
        endcase
    endfunction

    function automatic logic get_hold(int i);
        case (i)
            0: return h0;
            1: return h1;
            default: return h2;
        endcase
    endfunction

    function automatic int get_sel(int i);
        case (i)
            0: return int'(s0);
            1: return int'(s1);
            default: return int'(s2);
        endcase
    endfunction

    function automatic logic [7:0] get_word(int i, int k);
        case (i)
            0: return {4'h0, d0[k*4 +: 4]};
            1: return d1[k*8 +: 8];
            default: return d2[k*8 +: 8];
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            n_cap[i]  = 0;
            prev_c[i] = (EDG_T[i] == 0);
            stb_e[i]  = 1'b0;
        end
    endtask

    task automatic model_clock();
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic c, ed, cap;
                int   s;
                c   = get_cen(i);
                ed  = (EDG_T[i] == 0) ? (!c && prev_c[i]) : (c && !prev_c[i]);
                cap = ed && !get_hold(i);
                prev_c[i] = c;
                stb_e[i]  = cap;
                if (cap) begin
                    s = get_sel(i);
                    if (s >= NIN_T[i]) s = 0;
                    log_w[i][n_cap[i] % 4096] = get_word(i, s);
                    n_cap[i]++;
                end
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            logic [36:0] exp_v, act_v;
            logic [7:0]  eq;
            logic [23:0] eh;
            logic [2:0]  ehv;
            int n;
            n   = n_cap[i];
            eq  = (n > 0) ? log_w[i][(n-1) % 4096] : 8'h00;
            eh  = 24'h0;
            ehv = 3'b000;
            for (int j = 0; j < DEP_T[i]; j++) begin
                if (n >= j + 2) begin
                    eh     = eh | (24'(log_w[i][(n-2-j) % 4096]) << (j * W_T[i]));
                    ehv[j] = 1'b1;
                end
            end
            exp_v = {eq, eh, ehv, (n > 0), stb_e[i]};
            case (i)
                0: act_v = {4'h0, q0, 20'h0, hh0, 2'b00, hv0, qv0, stb0};
                1: act_v = {q1, hh1, hv1, qv1, stb1};
                default: act_v = {q2, 8'h00, hh2, 1'b0, hv2, qv2, stb2};
            endcase
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model_u%0d cycle %0d: got %h expected %h", i, cyc, act_v, exp_v);
            end
        end
    endtask

    task automatic hcheck(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_clock();
        #1;
        check_model();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_model();
        step();
        rst = 1'b0;
    endtask

    task automatic cap1(logic [1:0] sel, logic [23:0] d);
        c1 = 1'b0; s1 = sel; d1 = d;
        step();
        c1 = 1'b1;
        step();
    endtask

    typedef struct {
        logic       cen;
        logic       hold;
        logic [0:0] sel;
        logic [7:0] d;
        logic [3:0] q;
        logic       qv;
        logic       stb;
        logic [3:0] h;
        logic       hv;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t v(logic cen, logic hold, logic [0:0] sel, logic [7:0] d,
                               logic [3:0] q, logic qv, logic stb, logic [3:0] h, logic hv);
        vec_t r;
        r.cen = cen; r.hold = hold; r.sel = sel; r.d = d;
        r.q = q; r.qv = qv; r.stb = stb; r.h = h; r.hv = hv;
        return r;
    endfunction

    initial begin
        // Basic capture: D = {B=A, A=5}
        tbl.push_back(v(1'b1, 1'b0, 1'b1, 8'hA5, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 1'b1, 8'hA5, 4'hA, 1'b1, 1'b1, 4'h0, 1'b0));
        tbl.push_back(v(1'b1, 1'b0, 1'b0, 8'hA5, 4'hA, 1'b1, 1'b0, 4'h0, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 1'b0, 8'hA5, 4'h5, 1'b1, 1'b1, 4'hA, 1'b1));
        // Cen held low: no further captures even though D changes
        for (int k = 0; k < 9; k++)
            tbl.push_back(v(1'b0, 1'b0, 1'b0, 8'h3C, 4'h5, 1'b1, 1'b0, 4'hA, 1'b1));
        // Toggle every cycle: capture on every second cycle
        tbl.push_back(v(1'b1, 1'b0, 1'b0, 8'h3C, 4'h5, 1'b1, 1'b0, 4'hA, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 1'b0, 8'h3C, 4'hC, 1'b1, 1'b1, 4'h5, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 1'b1, 8'h3C, 4'hC, 1'b1, 1'b0, 4'h5, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 1'b1, 8'h3C, 4'h3, 1'b1, 1'b1, 4'hC, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 1'b0, 8'h3C, 4'h3, 1'b1, 1'b0, 4'hC, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 1'b0, 8'h3C, 4'hC, 1'b1, 1'b1, 4'h3, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 1'b1, 8'h3C, 4'hC, 1'b1, 1'b0, 4'h3, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 1'b1, 8'h3C, 4'h3, 1'b1, 1'b1, 4'hC, 1'b1));
        // HOLD swallows the edge; releasing HOLD with Cen low does not capture
        tbl.push_back(v(1'b1, 1'b0, 1'b0, 8'h3C, 4'h3, 1'b1, 1'b0, 4'hC, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, 1'b0, 8'h3C, 4'h3, 1'b1, 1'b0, 4'hC, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 1'b0, 8'h3C, 4'h3, 1'b1, 1'b0, 4'hC, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 1'b0, 8'h3C, 4'h3, 1'b1, 1'b0, 4'hC, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 1'b0, 8'h3C, 4'h3, 1'b1, 1'b0, 4'hC, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 1'b0, 8'h3C, 4'hC, 1'b1, 1'b1, 4'h3, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 1'b0, 8'h3C, 4'hC, 1'b1, 1'b0, 4'h3, 1'b1));

        rst = 1'b0;
        c0 = 1'b1; h0 = 1'b0; s0 = 1'b1; d0 = 8'hA5;
        c1 = 1'b1; h1 = 1'b0; s1 = 2'd0; d1 = 24'h0;
        c2 = 1'b0; h2 = 1'b0; s2 = 2'd0; d2 = 24'h0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model();
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t r;
            r  = tbl[i];
            c0 = r.cen; h0 = r.hold; s0 = r.sel; d0 = r.d;
            step();
            n_tests++;
            if ({q0, hh0, hv0, qv0, stb0} !== {r.q, r.h, r.hv, r.qv, r.stb}) begin
                n_fail++;
                $display("FAIL vec%0d: got q=%h h=%h hv=%b qv=%b stb=%b expected q=%h h=%h hv=%b qv=%b stb=%b",
                         i, q0, hh0, hv0, qv0, stb0, r.q, r.h, r.hv, r.qv, r.stb);
            end
        end

        // History fill on u1
        cap1(2'd0, 24'h000011);
        cap1(2'd1, 24'h002200);
        cap1(2'd2, 24'h330000);
        cap1(2'd0, 24'h000044);
        cap1(2'd1, 24'h005500);
        hcheck("hist_q", 32'(q1), 32'h55);
        hcheck("hist_h", 32'(hh1), 32'h223344);
        hcheck("hist_hv", 32'(hv1), 32'h7);
        cap1(2'd3, 24'hAABBCC);
        hcheck("sel_oob", 32'(q1), 32'hCC);

        // Rising-edge mode on u2, then reset mid-stream
        c2 = 1'b1; s2 = 2'd1; d2 = 24'h000700;
        step();
        hcheck("rise_q", 32'({q2, stb2}), 32'({8'h07, 1'b1}));
        c2 = 1'b0;
        step();
        rst = 1'b1;
        #1;
        model_reset();
        check_model();
        hcheck("rst_now", 32'({q2, hh2, hv2, qv2, stb2}), 32'h0);
        c2 = 1'b1; s2 = 2'd2; d2 = 24'h090000;
        step();
        rst = 1'b0;
        step();
        hcheck("post_rst", 32'({q2, qv2, stb2}), 32'({8'h09, 1'b1, 1'b1}));

        // Randomised stress across all three instances
        for (int t = 0; t < 800; t++) begin
            c0 = 1'($urandom_range(0, 1));
            c1 = 1'($urandom_range(0, 1));
            c2 = 1'($urandom_range(0, 1));
            h0 = ($urandom_range(0, 3) == 0);
            h1 = ($urandom_range(0, 3) == 0);
            h2 = ($urandom_range(0, 3) == 0);
            s0 = 1'($urandom_range(0, 1));
            s1 = 2'($urandom_range(0, 3));
            s2 = 2'($urandom_range(0, 3));
            d0 = 8'($urandom);
            d1 = 24'($urandom);
            d2 = 24'($urandom);
            if ($urandom_range(0, 79) == 0) begin
                pulse_reset();
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
